ifetch_line_unit: RTL and testbench
===================================

// Module: ifetch_line_unit
// PURPOSE
//  Parametrised instruction-fetch stage with a one-line fetch buffer and a miss handshake to memory.
//  Holds the PC and one cached instruction line (LINE_WORDS words, tagged).
//  Serves instructions from that line on a hit. On a miss, runs a req/ack refill.
//  Applies branch redirects and downstream stalls.
//  Feeds the decode stage; successor to the fixed 4-word, externally-hit-driven fetch block.
// PARAMETERS
//  ADDR_W      32  PC / address width
//  DATA_W      32  instruction width
//  LINE_WORDS  4   words per memory line (power of 2, >=2)
//  RESET_PC    0   PC value loaded on reset (word aligned)
// PORTS
//  clk           in   1                  clock, rising edge
//  rstn          in   1                  asynchronous, active-low reset
//  istall        in   1                  downstream hold; PC must not advance
//  iSIG_PCSrc    in   1                  1 = take branch to iaddr4branch
//  iaddr4branch  in   ADDR_W             branch target
//  iflush        in   1                  invalidate fetch buffer
//  omem_req      out  1                  line refill request (registered)
//  omem_addr     out  ADDR_W             line-aligned refill address, stable while omem_req=1
//  imem_ack      in   1                  refill data valid this cycle
//  imem_in       in   DATA_W*LINE_WORDS  refill line, word 0 in LSBs
//  oins          out  DATA_W             current instruction
//  ovalid        out  1                  oins valid
//  opc           out  ADDR_W             PC of oins
//  obranch_adder out  ADDR_W             opc + 4
// BEHAVIOUR
//  Reset (async, rstn=0):
//   pc=RESET_PC, buf_valid=0, state=RUN, omem_req=0, omem_addr=0.
//   Hence ovalid=0, oins=0, opc=RESET_PC, obranch_adder=RESET_PC+4.
//  Addressing:
//   word index = pc[2 +: log2(LINE_WORDS)]; tag = pc[ADDR_W-1 : 2+log2(LINE_WORDS)].
//   pc[1:0] always 0; branch target bits [1:0] ignored (forced 0).
//   pc+4 wraps modulo 2^ADDR_W.
//  hit = state==RUN && buf_valid && buf_tag==tag(pc).
//   ovalid=hit (combinational from registers).
//   oins = selected buffer word when ovalid, else 0.
//  FSM RUN:
//   hit && !istall: pc <= iSIG_PCSrc ? target : pc+4.
//   hit && istall: pc holds, unless iSIG_PCSrc=1 (redirect wins over stall).
//   !hit: next state MISS; omem_req<=1; omem_addr<=line base of the pc in effect next edge
//    (the branch target if iSIG_PCSrc=1).
//  FSM MISS:
//   omem_req and omem_addr held until imem_ack=1.
//   On ack: buffer<=imem_in, buf_tag<=tag(omem_addr), buf_valid<=!flush_pend.
//    omem_req<=0, state<=RUN.
//   iSIG_PCSrc=1 during MISS: pc<=target immediately; request not aborted.
//    After refill, a tag mismatch causes a fresh miss.
//   imem_ack while omem_req=0: ignored.
//  Flush:
//   iflush in RUN: buf_valid<=0 next edge; ovalid drops next cycle.
//   iflush in MISS (incl. the ack cycle): flush_pend set; refill completes but buf_valid stays 0.
//   flush_pend clears on return to RUN.
//  Min miss penalty: miss seen cycle N; req high N+1; ack at N+1 gives hit at N+2.
//  Reset mid-refill: request dropped at once; late ack ignored.
// TESTING
//  1 Reset, RESET_PC=0:
//    omem_req=1 after the first edge with omem_addr=0.
//    ack with line {w3,w2,w1,w0}=0x..33/22/11/00 -> oins=0x00,0x11,0x22,0x33 on consecutive cycles, ovalid=1.
//  2 Sequential fetch across a line edge at pc=0xC:
//    next cycle ovalid=0, omem_addr=0x10; ack -> opc=0x10, obranch_adder=0x14.
//  3 istall=1 for 3 cycles on a hit: opc and oins constant, ovalid=1; release -> pc+4.
//  4 Branch inside the buffered line (pc=0x4 -> 0x8): no miss, oins=w2 next cycle.
//    Branch to 0x40 during MISS: after ack, a second miss with omem_addr=0x40.
//  5 iflush on a hit -> ovalid=0 next cycle, refill of the same line.
//    iflush during MISS -> after ack, another miss to the same address.
//  6 rstn low while omem_req=1: omem_req=0 immediately, opc=RESET_PC; ack 2 cycles later has no effect.
//    LINE_WORDS=8 run of scenario 1 checks word indexing.

Source files
------------

// File: rtl/ifetch_line_unit_if.sv
// ifetch_line_unit_if: line refill handshake between the fetch unit and memory
interface ifetch_line_unit_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
);
  logic                         omem_req;
  logic [ADDR_W-1:0]            omem_addr;
  logic                         imem_ack;
  logic [DATA_W*LINE_WORDS-1:0] imem_in;
  modport master (output omem_req, omem_addr, input imem_ack, imem_in);
  modport slave  (input omem_req, omem_addr, output imem_ack, imem_in);
endinterface

// File: rtl/ifetch_line_unit.sv
// ifetch_line_unit: fetch stage with a one-line tagged buffer, req/ack refill, redirects and stalls
module ifetch_line_unit #(
  parameter int               ADDR_W     = 32,
  parameter int               DATA_W     = 32,
  parameter int               LINE_WORDS = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              istall,
  input  logic              iSIG_PCSrc,
  input  logic [ADDR_W-1:0] iaddr4branch,
  input  logic              iflush,
  ifetch_line_unit_if.master mem,
  output logic [DATA_W-1:0] oins,
  output logic              ovalid,
  output logic [ADDR_W-1:0] opc,
  output logic [ADDR_W-1:0] obranch_adder
);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * 4 - 1);
  typedef enum logic {RUN, MISS} state_t;
  state_t                       state_q, state_d;
  logic [ADDR_W-1:0]            pc_q, pc_d, addr_q, addr_d;
  logic [DATA_W*LINE_WORDS-1:0] buf_q, buf_d;
  logic [TAG_W-1:0]             tag_q, tag_d;
  logic                         valid_q, valid_d, flush_pend_q, flush_pend_d, req_q, req_d;
  logic                         hit;
  logic [ADDR_W-1:0]            target, pc_inc;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      addr_q       <= '0;
      buf_q        <= '0;
      tag_q        <= '0;
      valid_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      buf_q        <= buf_d;
      tag_q        <= tag_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      req_q        <= req_d;
    end
  end
  always_comb begin
    state_d      = state_q;
    pc_d         = iSIG_PCSrc ? target : pc_q;
    addr_d       = addr_q;
    buf_d        = buf_q;
    tag_d        = tag_q;
    valid_d      = valid_q & ~iflush;
    flush_pend_d = flush_pend_q;
    req_d        = req_q;
    if (state_q == RUN) begin
      pc_d = (hit && !istall && !iSIG_PCSrc) ? pc_inc : pc_d;
      if (!hit) begin
        state_d = MISS;
        req_d   = 1'b1;
        addr_d  = pc_d & LINE_MASK;
      end
    end else begin
      flush_pend_d = flush_pend_q | iflush;
      // a flush seen at any point of the refill, including the ack cycle, keeps the new line invalid
      if (mem.imem_ack) begin
        buf_d        = mem.imem_in;
        tag_d        = addr_q[ADDR_W-1 -: TAG_W];
        valid_d      = !(flush_pend_q || iflush);
        flush_pend_d = 1'b0;
        req_d        = 1'b0;
        state_d      = RUN;
      end
    end
  end
  always_comb begin
    target        = iaddr4branch & ~ADDR_W'(3);
    pc_inc        = pc_q + ADDR_W'(4);
    hit           = state_q == RUN && valid_q && tag_q == pc_q[ADDR_W-1 -: TAG_W];
    ovalid        = hit;
    oins          = hit ? buf_q[pc_q[2 +: IDX_W] * DATA_W +: DATA_W] : '0;
    opc           = pc_q;
    obranch_adder = pc_inc;
  end
  assign mem.omem_req  = req_q;
  assign mem.omem_addr = addr_q;
endmodule

// File: tb/tb_ifetch_line_unit.sv
// tb_ifetch_line_unit: directed scenario tests for ifetch_line_unit (4- and 8-word lines)
module tb_ifetch_line_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rstn, istall, pcsrc, flush, ovalid;
  logic [31:0] br, oins, opc, oba;
  logic        rstn8, ovalid8;
  logic [31:0] oins8, opc8, oba8;
  int tests = 0;
  int fails = 0;
  ifetch_line_unit_if #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)) m ();
  ifetch_line_unit_if #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(8)) m8 ();
  ifetch_line_unit #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rstn(rstn), .istall(istall), .iSIG_PCSrc(pcsrc), .iaddr4branch(br),
    .iflush(flush), .mem(m), .oins(oins), .ovalid(ovalid), .opc(opc), .obranch_adder(oba));
  ifetch_line_unit #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(8), .RESET_PC(32'h0)) dut8 (
    .clk(clk), .rstn(rstn8), .istall(1'b0), .iSIG_PCSrc(1'b0), .iaddr4branch(32'h0),
    .iflush(1'b0), .mem(m8), .oins(oins8), .ovalid(ovalid8), .opc(opc8), .obranch_adder(oba8));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rstn = 1'b0; rstn8 = 1'b0; istall = 1'b0; pcsrc = 1'b0; flush = 1'b0; br = '0;
    m.imem_ack = 1'b0; m.imem_in = '0; m8.imem_ack = 1'b0; m8.imem_in = '0;
    #3;
    tests++;
    if ({ovalid, oins, opc, oba, m.omem_req, m.omem_addr} !== {1'b0, 32'h0, 32'h0, 32'h4, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL reset_state: valid=%b ins=%h pc=%h ba=%h req=%b addr=%h, want 0 0 0 4 0 0", ovalid, oins, opc, oba, m.omem_req, m.omem_addr);
    end
    @(negedge clk);
    rstn = 1'b1;
    tick();
    tests++;
    if ({ovalid, m.omem_req, m.omem_addr} !== {1'b0, 1'b1, 32'h0}) begin
      fails++;
      $display("FAIL first_miss: valid=%b req=%b addr=%h, want 0 1 0", ovalid, m.omem_req, m.omem_addr);
    end
  endtask
  task automatic test_refill();
    m.imem_ack = 1'b1;
    m.imem_in  = {32'h33, 32'h22, 32'h11, 32'h00};
    tick();
    m.imem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if ({ovalid, oins, opc} !== {1'b1, 32'h11 * k, 32'(4 * k)}) begin
        fails++;
        $display("FAIL refill_word%0d: valid=%b ins=%h pc=%h, want 1 %h %h", k, ovalid, oins, opc, 32'h11 * k, 4 * k);
      end
      tick();
    end
  endtask
  task automatic test_line_cross();
    tests++;
    if ({ovalid, opc, m.omem_req} !== {1'b0, 32'h10, 1'b0}) begin
      fails++;
      $display("FAIL cross_miss: valid=%b pc=%h req=%b, want 0 10 0", ovalid, opc, m.omem_req);
    end
    tick();
    tests++;
    if ({m.omem_req, m.omem_addr} !== {1'b1, 32'h10}) begin
      fails++;
      $display("FAIL cross_req: req=%b addr=%h, want 1 10", m.omem_req, m.omem_addr);
    end
    m.imem_ack = 1'b1;
    m.imem_in  = {32'h73, 32'h72, 32'h71, 32'h70};
    tick();
    m.imem_ack = 1'b0;
    tests++;
    if ({ovalid, oins, opc, oba} !== {1'b1, 32'h70, 32'h10, 32'h14}) begin
      fails++;
      $display("FAIL cross_hit: valid=%b ins=%h pc=%h ba=%h, want 1 70 10 14", ovalid, oins, opc, oba);
    end
  endtask
  task automatic test_stall();
    istall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if ({ovalid, oins, opc} !== {1'b1, 32'h70, 32'h10}) begin
        fails++;
        $display("FAIL stall%0d: valid=%b ins=%h pc=%h, want 1 70 10", k, ovalid, oins, opc);
      end
    end
    istall = 1'b0;
    tick();
    tests++;
    if ({ovalid, oins, opc} !== {1'b1, 32'h71, 32'h14}) begin
      fails++;
      $display("FAIL stall_release: valid=%b ins=%h pc=%h, want 1 71 14", ovalid, oins, opc);
    end
  endtask
  task automatic test_branch();
    pcsrc = 1'b1; br = 32'h1B;
    tick();
    pcsrc = 1'b0;
    tests++;
    if ({ovalid, oins, opc, m.omem_req} !== {1'b1, 32'h72, 32'h18, 1'b0}) begin
      fails++;
      $display("FAIL branch_in_line: valid=%b ins=%h pc=%h req=%b, want 1 72 18 0", ovalid, oins, opc, m.omem_req);
    end
    pcsrc = 1'b1; br = 32'h0;
    tick();
    pcsrc = 1'b0;
    tests++;
    if ({ovalid, opc} !== {1'b0, 32'h0}) begin
      fails++;
      $display("FAIL branch_out: valid=%b pc=%h, want 0 0", ovalid, opc);
    end
    tick();
    pcsrc = 1'b1; br = 32'h40;
    tick();
    pcsrc = 1'b0;
    tests++;
    if ({opc, m.omem_req, m.omem_addr} !== {32'h40, 1'b1, 32'h0}) begin
      fails++;
      $display("FAIL branch_in_miss: pc=%h req=%b addr=%h, want 40 1 0", opc, m.omem_req, m.omem_addr);
    end
    m.imem_ack = 1'b1;
    m.imem_in  = {32'h33, 32'h22, 32'h11, 32'h00};
    tick();
    m.imem_ack = 1'b0;
    tests++;
    if ({ovalid, opc, m.omem_req} !== {1'b0, 32'h40, 1'b0}) begin
      fails++;
      $display("FAIL stale_refill: valid=%b pc=%h req=%b, want 0 40 0", ovalid, opc, m.omem_req);
    end
    tick();
    tests++;
    if ({m.omem_req, m.omem_addr} !== {1'b1, 32'h40}) begin
      fails++;
      $display("FAIL second_miss: req=%b addr=%h, want 1 40", m.omem_req, m.omem_addr);
    end
    m.imem_ack = 1'b1;
    m.imem_in  = {32'h43, 32'h42, 32'h41, 32'h40};
    tick();
    m.imem_ack = 1'b0;
    tests++;
    if ({ovalid, oins, opc} !== {1'b1, 32'h40, 32'h40}) begin
      fails++;
      $display("FAIL branch_hit: valid=%b ins=%h pc=%h, want 1 40 40", ovalid, oins, opc);
    end
  endtask
  task automatic test_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests++;
    if ({ovalid, opc} !== {1'b0, 32'h44}) begin
      fails++;
      $display("FAIL flush_run: valid=%b pc=%h, want 0 44", ovalid, opc);
    end
    tick();
    tests++;
    if ({m.omem_req, m.omem_addr} !== {1'b1, 32'h40}) begin
      fails++;
      $display("FAIL flush_refetch: req=%b addr=%h, want 1 40", m.omem_req, m.omem_addr);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    m.imem_ack = 1'b1;
    tick();
    m.imem_ack = 1'b0;
    tests++;
    if ({ovalid, opc, m.omem_req} !== {1'b0, 32'h44, 1'b0}) begin
      fails++;
      $display("FAIL flush_miss_refill: valid=%b pc=%h req=%b, want 0 44 0", ovalid, opc, m.omem_req);
    end
    tick();
    tests++;
    if ({m.omem_req, m.omem_addr} !== {1'b1, 32'h40}) begin
      fails++;
      $display("FAIL flush_miss_again: req=%b addr=%h, want 1 40", m.omem_req, m.omem_addr);
    end
    m.imem_ack = 1'b1;
    tick();
    m.imem_ack = 1'b0;
    tests++;
    if ({ovalid, oins, opc} !== {1'b1, 32'h41, 32'h44}) begin
      fails++;
      $display("FAIL flush_recover: valid=%b ins=%h pc=%h, want 1 41 44", ovalid, oins, opc);
    end
  endtask
  task automatic test_reset_mid_refill();
    pcsrc = 1'b1; br = 32'h80;
    tick();
    pcsrc = 1'b0;
    tick();
    tests++;
    if ({m.omem_req, m.omem_addr} !== {1'b1, 32'h80}) begin
      fails++;
      $display("FAIL pre_reset_req: req=%b addr=%h, want 1 80", m.omem_req, m.omem_addr);
    end
    #2;
    rstn = 1'b0;
    #1;
    tests++;
    if ({m.omem_req, opc, ovalid} !== {1'b0, 32'h0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: req=%b pc=%h valid=%b, want 0 0 0", m.omem_req, opc, ovalid);
    end
    m.imem_ack = 1'b1;
    m.imem_in  = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
    tick();
    tick();
    @(negedge clk);
    rstn = 1'b1;
    tick();
    tests++;
    if ({ovalid, m.omem_req, m.omem_addr} !== {1'b0, 1'b1, 32'h0}) begin
      fails++;
      $display("FAIL late_ack_ignored: valid=%b req=%b addr=%h, want 0 1 0", ovalid, m.omem_req, m.omem_addr);
    end
    m.imem_ack = 1'b0;
    tick();
    tests++;
    if ({ovalid, m.omem_req} !== {1'b0, 1'b1}) begin
      fails++;
      $display("FAIL post_reset_wait: valid=%b req=%b, want 0 1", ovalid, m.omem_req);
    end
  endtask
  task automatic test_line8();
    @(negedge clk);
    rstn8 = 1'b1;
    tick();
    tests++;
    if ({m8.omem_req, m8.omem_addr} !== {1'b1, 32'h0}) begin
      fails++;
      $display("FAIL l8_miss: req=%b addr=%h, want 1 0", m8.omem_req, m8.omem_addr);
    end
    for (int k = 0; k < 8; k++) m8.imem_in[k*32 +: 32] = 32'h11 * k;
    m8.imem_ack = 1'b1;
    tick();
    m8.imem_ack = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tests++;
      if ({ovalid8, oins8, opc8} !== {1'b1, 32'h11 * k, 32'(4 * k)}) begin
        fails++;
        $display("FAIL l8_word%0d: valid=%b ins=%h pc=%h, want 1 %h %h", k, ovalid8, oins8, opc8, 32'h11 * k, 4 * k);
      end
      tick();
    end
    tests++;
    if ({ovalid8, opc8} !== {1'b0, 32'h20}) begin
      fails++;
      $display("FAIL l8_line_end: valid=%b pc=%h, want 0 20", ovalid8, opc8);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_refill();
    test_line_cross();
    test_stall();
    test_branch();
    test_flush();
    test_reset_mid_refill();
    test_line8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
